// File: rtl/spi_reg_burst.sv
// spi_reg_burst: SPI slave register bridge with runtime CPOL/CPHA, REG_W-bit burst read/write and fast commands.
// Define SPI_REG_BURST_FRAME_ERR_EN to add the sticky frame_err output.
module spi_reg_burst #(
  parameter int ADDR_W   = 3,
  parameter int REG_W    = 8,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              sclk,
  input  logic              nss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              cpol,
  input  logic              cpha,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rd_stb,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_vld,
  input  logic [7:0]        status,
  output logic [5:0]        fastcmd,
  output logic              fastcmd_vld
`ifdef SPI_REG_BURST_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);
  localparam logic [2:0] S_WAIT = 3'd0, S_IDLE = 3'd1, S_CMD = 3'd2, S_DATA = 3'd3, S_HOLD = 3'd4;
  logic [2:0] sclk_q;
  logic [1:0] nss_q, mosi_q;
  logic [2:0] st_q, st_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, first_q, first_d, wr_q, wr_d, pend_q, pend_d;
  logic [REG_W-1:0] osr_q, osr_d, dout_q, dout_d, sh;
  logic [REG_W-2:0] isr_q, isr_d;
  logic [5:0] cnt_q, cnt_d, fc_q, fc_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic rd_q, rd_d, vld_q, vld_d, fcv_q, fcv_d;
  logic rise, fall, lead, trail, smp, shf, active, cmd_done, err;
  logic [7:0] st8;
  assign rise     = sclk_q[1] & ~sclk_q[2];
  assign fall     = ~sclk_q[1] & sclk_q[2];
  assign lead     = cpol_q ? fall : rise;
  assign trail    = cpol_q ? rise : fall;
  assign smp      = cpha_q ? trail : lead;
  // With CPHA=1 the first leading edge must not shift: the status MSB is already on the wire.
  assign shf      = cpha_q ? (lead & ~first_q) : trail;
  assign active   = (st_q == S_CMD) | (st_q == S_DATA);
  assign cmd_done = (st_q == S_CMD) & ~nss_q[1] & smp & (cnt_q == 6'd7);
  assign sh       = {isr_q, mosi_q[1]};
  assign addr_nxt = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + ADDR_W'(1);
  assign st8      = {status[7] | err, status[6:0]};
  assign miso     = ((st_q == S_CMD) | ((st_q == S_DATA) & ~wr_q)) & osr_q[REG_W-1];
  assign miso_oe  = active | (st_q == S_HOLD);
  assign reg_addr       = addr_q;
  assign reg_rd_stb     = rd_q;
  assign reg_data_o     = dout_q;
  assign reg_data_o_vld = vld_q;
  assign fastcmd        = fc_q;
  assign fastcmd_vld    = fcv_q;
`ifdef SPI_REG_BURST_FRAME_ERR_EN
  logic err_q, err_d;
  assign err       = err_q;
  assign frame_err = err_q;
  always_comb begin
    err_d = err_q;
    if (active & nss_q[1] & (cnt_q != 6'd0)) err_d = 1'b1;
    else if (cmd_done & (sh[7:6] == 2'b01)) err_d = 1'b1;
    else if (cmd_done & (sh[7:0] == 8'hFF)) err_d = 1'b0;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) err_q <= 1'b0;
    else err_q <= err_d;
  end
`else
  assign err = 1'b0;
`endif
  always_comb begin
    st_d   = st_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    first_d = first_q;
    wr_d   = wr_q;
    pend_d = pend_q;
    osr_d  = osr_q;
    isr_d  = isr_q;
    dout_d = dout_q;
    cnt_d  = cnt_q;
    fc_d   = fc_q;
    rd_d   = 1'b0;
    vld_d  = 1'b0;
    fcv_d  = 1'b0;
    addr_d = (rd_q | vld_q) ? addr_nxt : addr_q;
    if (st_q == S_WAIT) st_d = nss_q[1] ? S_IDLE : S_WAIT;
    else if (nss_q[1]) st_d = S_IDLE;
    else if (st_q == S_IDLE) begin
      st_d    = S_CMD;
      cpol_d  = cpol;
      cpha_d  = cpha;
      first_d = 1'b1;
      pend_d  = 1'b0;
      cnt_d   = '0;
      osr_d   = '0;
      osr_d[REG_W-1 -: 8] = st8;
    end else if (active) begin
      if (lead) first_d = 1'b0;
      if (shf) begin
        osr_d  = pend_q ? reg_data_i : osr_q << 1;
        rd_d   = pend_q;
        pend_d = 1'b0;
      end
      if (smp) begin
        isr_d = sh[REG_W-2:0];
        cnt_d = cnt_q + 6'd1;
        if (cmd_done) begin
          cnt_d  = '0;
          wr_d   = sh[7];
          st_d   = sh[6] ? S_HOLD : S_DATA;
          pend_d = ~sh[7] & ~sh[6];
          fc_d   = (sh[7:6] == 2'b11) ? sh[5:0] : fc_q;
          fcv_d  = sh[7:6] == 2'b11;
          if (!sh[6]) addr_d = sh[ADDR_W-1:0];
        end else if ((st_q == S_DATA) && (cnt_q == 6'(REG_W - 1))) begin
          cnt_d  = '0;
          dout_d = wr_q ? sh : dout_q;
          vld_d  = wr_q;
          pend_d = ~wr_q;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sclk_q  <= '0;
      nss_q   <= '0;
      mosi_q  <= '0;
      st_q    <= S_WAIT;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      first_q <= 1'b0;
      wr_q    <= 1'b0;
      pend_q  <= 1'b0;
      osr_q   <= '0;
      isr_q   <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      fc_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      vld_q   <= 1'b0;
      fcv_q   <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      nss_q   <= {nss_q[0], nss};
      mosi_q  <= {mosi_q[0], mosi};
      st_q    <= st_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      first_q <= first_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      osr_q   <= osr_d;
      isr_q   <= isr_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      vld_q   <= vld_d;
      fcv_q   <= fcv_d;
    end
  end
endmodule
